// File: rtl/fft_helpers_twiddle_stream.sv
// Streaming twiddle-factor generator: emits cos/sin(2*pi*k*step/N), k = 0..count-1,
// over a valid/ready handshake through a two-stage pipeline (phase fold, ROM + sign).
// Optional build macro FFT_TWIDDLE_FULL_TABLE_EN: use full N-entry sine and cosine ROMs
// indexed directly by phase instead of a folded quarter-wave ROM. Outputs are bit-identical.
module fft_helpers_twiddle_stream #(
  parameter int N = 8,
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [$clog2(N)-1:0] step,
  input  logic [$clog2(N):0]   count,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_cos,
  output logic [W-1:0]         out_sin,
  output logic [$clog2(N)-1:0] out_idx
);
  localparam int PW = $clog2(N);
  localparam int QN = N / 4;

  if (N < 4 || (1 << PW) != N || D >= 32 || W < D + 2) begin : g_param_chk
    $error("fft_helpers_twiddle_stream: illegal N/W/D combination");
  end

  // round_nearest(sin(2*pi*i/N) * 2**D); real-to-integer casts round to nearest
  function automatic longint sin_round(input int i);
    real v;
    v = $sin(2.0 * $acos(-1.0) * real'(i) / real'(N)) * (2.0 ** D);
    return longint'(v);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] step_q, step_d, phase_q, phase_d;
  logic [PW:0]   cnt_q, cnt_d, iss_q, iss_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          s1_vld_q, s1_vld_d;
  logic [PW-1:0] s1_idx_q, s1_idx_d, s1_sadr_q, s1_sadr_d, s1_cadr_q, s1_cadr_d;
  logic          s1_sneg_q, s1_sneg_d, s1_cneg_q, s1_cneg_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_cos_q, out_cos_d, out_sin_q, out_sin_d;
  logic [PW-1:0] out_idx_q, out_idx_d;
  logic          advance, issue;
  logic [W-1:0]  smag, cmag;

`ifdef FFT_TWIDDLE_FULL_TABLE_EN
  // Full-turn sine built from the same rounded quarter-wave values, so results match the folded build
  function automatic longint fold_sin(input int p);
    int q, r;
    q = p / QN;
    r = p % QN;
    case (q)
      0:       return  sin_round(r);
      1:       return  sin_round(QN - r);
      2:       return -sin_round(r);
      default: return -sin_round(QN - r);
    endcase
  endfunction

  logic [W-1:0] srom [N];
  logic [W-1:0] crom [N];
  for (genvar i = 0; i < N; i++) begin : g_rom
    assign srom[i] = W'(fold_sin(i));
    assign crom[i] = W'(fold_sin((i + QN) % N));  // cos(p) = sin(p + quarter turn)
  end
`else
  // Quarter-wave ROM, entries 0..N/4; upper slots are unused padding so the index is exactly PW bits
  logic [W-1:0] qrom [N];
  for (genvar i = 0; i < N; i++) begin : g_rom
    if (i <= QN) begin : g_val
      assign qrom[i] = W'(sin_round(i));
    end else begin : g_pad
      assign qrom[i] = '0;
    end
  end
`endif

  assign advance = !out_valid_q || out_ready;
  assign issue   = (state_q == RUN) && advance;

  // Control FSM: latch step/count on accepted start, issue phases, wait for last handshake
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    iss_d   = iss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (count != '0) begin
          state_d = RUN;
          step_d  = step;
          cnt_d   = count;
          phase_d = '0;
          iss_d   = '0;
          busy_d  = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      RUN: if (issue) begin
        phase_d = phase_q + step_q;
        iss_d   = iss_q + 1'b1;
        if (iss_q + 1'b1 == cnt_q) state_d = DRAIN;
      end
      DRAIN: if (out_valid_q && out_ready && !s1_vld_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: turn the phase into ROM addresses and sign flags
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_idx_d  = s1_idx_q;
    s1_sadr_d = s1_sadr_q;
    s1_cadr_d = s1_cadr_q;
    s1_sneg_d = s1_sneg_q;
    s1_cneg_d = s1_cneg_q;
    if (advance) begin
      s1_vld_d = issue;
      if (issue) begin
        s1_idx_d = iss_q[PW-1:0];
`ifdef FFT_TWIDDLE_FULL_TABLE_EN
        s1_sadr_d = phase_q;
        s1_cadr_d = phase_q;
        s1_sneg_d = 1'b0;
        s1_cneg_d = 1'b0;
`else
        // quadrant q = phase MSBs, r = offset within quadrant; odd quadrants mirror the table
        s1_sadr_d = phase_q[PW-2] ? PW'(QN) - (phase_q & PW'(QN - 1)) : (phase_q & PW'(QN - 1));
        s1_cadr_d = phase_q[PW-2] ? (phase_q & PW'(QN - 1)) : PW'(QN) - (phase_q & PW'(QN - 1));
        s1_sneg_d = phase_q[PW-1];
        s1_cneg_d = phase_q[PW-1] ^ phase_q[PW-2];
`endif
      end
    end
  end

  // Stage 2: ROM read and sign application into the output registers
  always_comb begin
`ifdef FFT_TWIDDLE_FULL_TABLE_EN
    smag = srom[s1_sadr_q];
    cmag = crom[s1_cadr_q];
`else
    smag = qrom[s1_sadr_q];
    cmag = qrom[s1_cadr_q];
`endif
    out_valid_d = out_valid_q;
    out_cos_d   = out_cos_q;
    out_sin_d   = out_sin_q;
    out_idx_d   = out_idx_q;
    if (advance) begin
      out_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        out_cos_d = s1_cneg_q ? -cmag : cmag;
        out_sin_d = s1_sneg_q ? -smag : smag;
        out_idx_d = s1_idx_q;
      end
    end
  end

  // All state registers; async reset clears FSM, counters and pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      iss_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_sadr_q   <= '0;
      s1_cadr_q   <= '0;
      s1_sneg_q   <= 1'b0;
      s1_cneg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_cos_q   <= '0;
      out_sin_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      iss_q       <= iss_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s1_sadr_q   <= s1_sadr_d;
      s1_cadr_q   <= s1_cadr_d;
      s1_sneg_q   <= s1_sneg_d;
      s1_cneg_q   <= s1_cneg_d;
      out_valid_q <= out_valid_d;
      out_cos_q   <= out_cos_d;
      out_sin_q   <= out_sin_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_cos   = out_cos_q;
  assign out_sin   = out_sin_q;
  assign out_idx   = out_idx_q;
endmodule
